uart_pad_receiver: RTL and testbench

Serial receiver that turns a byte stream from the remote board into the player-2 paddle position. Sits directly upstream of the player-2 paddle controller inside the game logic: its `y_pad_uart` drives that controller's remote-position input, used when `sw[1]` selects remote play. It handles UART bit recovery, two-byte frame assembly and validation, range clamping, and a link-alive indication. Its outputs are consumed in the same clock domain as the rest of the game logic.

---
 rtl/pong_pkg.sv | 9 +
 rtl/uart_rx_byte.sv | 62 ++++++
 rtl/uart_pad_receiver.sv | 84 ++++++++
 tb/tb_uart_pad_receiver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and state encodings for the remote paddle link.
package pong_pkg;
  localparam logic [7:0] HDR_FLAG  = 8'h80;
  localparam logic [7:0] RSVD_MASK = 8'h60;
  localparam logic [9:0] Y_MAX     = 10'd668;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
  typedef enum logic {F_WAIT_HDR, F_WAIT_DATA} frame_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// UART byte recovery: 2-FF synchronizer, falling-edge start detect, mid-bit sampling.
module uart_rx_byte import pong_pkg::*; #(
  parameter int DIV = 564
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       stop_err
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  logic          s1, s2, prev;
  uart_state_t   state, nxt;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bitn, bitn_d;
  logic [7:0]    sh, sh_d;
  logic          bv_d, se_d;

  // Sync chain resets low so a line already low at release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0; s2 <= 1'b0; prev <= 1'b0;
      state <= U_IDLE; cnt <= '0; bitn <= '0; sh <= '0;
      byte_valid <= 1'b0; stop_err <= 1'b0;
    end else begin
      s1 <= rx; s2 <= s1; prev <= s2;
      state <= nxt; cnt <= cnt_d; bitn <= bitn_d; sh <= sh_d;
      byte_valid <= bv_d; stop_err <= se_d;
    end
  end

  always_comb begin
    nxt = state; cnt_d = cnt; bitn_d = bitn; sh_d = sh;
    bv_d = 1'b0; se_d = 1'b0;
    case (state)
      U_IDLE: if (prev && !s2) begin nxt = U_START; cnt_d = HALF; end
      U_START:
        if (cnt == '0) begin
          if (s2) nxt = U_IDLE;
          else begin nxt = U_DATA; cnt_d = FULL; bitn_d = '0; end
        end else cnt_d = cnt - 1'b1;
      U_DATA:
        if (cnt == '0) begin
          sh_d = {s2, sh[7:1]};
          cnt_d = FULL;
          bitn_d = bitn + 3'd1;
          if (bitn == 3'd7) nxt = U_STOP;
        end else cnt_d = cnt - 1'b1;
      U_STOP:
        if (cnt == '0) begin
          nxt = U_IDLE; bv_d = s2; se_d = !s2;
        end else cnt_d = cnt - 1'b1;
      default: nxt = U_IDLE;
    endcase
  end

  assign data = sh;
endmodule

// File: rtl/uart_pad_receiver.sv
// Remote paddle receiver: two-byte frame assembly, range clamp and link-alive timer.
module uart_pad_receiver import pong_pkg::*; #(
  parameter int         CLK_HZ        = 65_000_000,
  parameter int         BAUD          = 115_200,
  parameter logic [9:0] Y_MAX         = pong_pkg::Y_MAX,
  parameter logic [9:0] Y_RESET       = 10'd334,
  parameter int         TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timing_tick,
  input  logic       rx,
  output logic [9:0] y_pad_uart,
  output logic       pad_valid,
  output logic       link_up,
  output logic       frame_err
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int LW  = $clog2(TIMEOUT_TICKS + 1);

  logic [7:0]   data;
  logic         byte_valid, stop_err;
  frame_state_t fstate, fnxt;
  logic [4:0]   hi, hi_d;
  logic         tk, tk_d;
  logic [9:0]   y_d, y_full;
  logic         pv_d, fe_d, reload;
  logic [LW-1:0] link;
  logic         is_hdr, is_dat;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk(clk), .rst(rst), .rx(rx),
    .data(data), .byte_valid(byte_valid), .stop_err(stop_err)
  );

  assign is_hdr = (data & (HDR_FLAG | RSVD_MASK)) == HDR_FLAG;
  assign is_dat = (data & (HDR_FLAG | RSVD_MASK)) == 8'h00;
  assign y_full = {hi, data[4:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      fstate <= F_WAIT_HDR; hi <= '0; tk <= 1'b0;
      y_pad_uart <= Y_RESET; pad_valid <= 1'b0; frame_err <= 1'b0;
      link <= '0;
    end else begin
      fstate <= fnxt; hi <= hi_d; tk <= tk_d;
      y_pad_uart <= y_d; pad_valid <= pv_d; frame_err <= fe_d;
      if (reload) link <= LW'(TIMEOUT_TICKS);
      else if (timing_tick && link != '0) link <= link - 1'b1;
    end
  end

  // tk remembers one tick seen while waiting for the data byte; a second one abandons the frame.
  always_comb begin
    fnxt = fstate; hi_d = hi; tk_d = tk; y_d = y_pad_uart;
    pv_d = 1'b0; fe_d = 1'b0; reload = 1'b0;
    case (fstate)
      F_WAIT_HDR:
        if (byte_valid) begin
          if (is_hdr) begin hi_d = data[4:0]; tk_d = 1'b0; fnxt = F_WAIT_DATA; end
          else fe_d = 1'b1;
        end else if (stop_err) fe_d = 1'b1;
      F_WAIT_DATA:
        if (byte_valid) begin
          if (is_dat) begin
            y_d = (y_full > Y_MAX) ? Y_MAX : y_full;
            pv_d = 1'b1; reload = 1'b1; fnxt = F_WAIT_HDR;
          end else if (is_hdr) begin
            fe_d = 1'b1; hi_d = data[4:0]; tk_d = 1'b0;
          end else begin
            fe_d = 1'b1; fnxt = F_WAIT_HDR;
          end
        end else if (stop_err) begin
          fe_d = 1'b1; fnxt = F_WAIT_HDR;
        end else if (timing_tick) begin
          if (tk) fnxt = F_WAIT_HDR;
          else tk_d = 1'b1;
        end
      default: fnxt = F_WAIT_HDR;
    endcase
  end

  assign link_up = (link != '0);
endmodule

// File: tb/tb_uart_pad_receiver.sv
// Self-checking bench: serial stimulus against a byte-level frame model.
module tb_uart_pad_receiver;
  localparam int DIV = 16;

  logic clk = 1'b0, rst = 1'b0, timing_tick = 1'b0, rx = 1'b1;
  logic [9:0] y_pad_uart;
  logic pad_valid, link_up, frame_err;

  uart_pad_receiver #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .timing_tick(timing_tick), .rx(rx),
    .y_pad_uart(y_pad_uart), .pad_valid(pad_valid), .link_up(link_up), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int pv_cnt = 0, fe_cnt = 0, pv_wide = 0, both = 0;
  logic pv_prev = 1'b0;

  always @(negedge clk) begin
    if (pad_valid) pv_cnt++;
    if (frame_err) fe_cnt++;
    if (pad_valid && pv_prev) pv_wide++;
    if (pad_valid && frame_err) both++;
    pv_prev = pad_valid;
  end

  // Reference model, tracked per whole byte / tick
  logic [9:0] exp_y = 10'd334;
  int exp_pv = 0, exp_fe = 0, exp_link = 0, ticks_waiting = 0;
  bit have_hi = 0;
  logic [4:0] m_hi = '0;

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    int y;
    if (!stop_ok) begin exp_fe++; have_hi = 0; end
    else if (b[7] && b[6:5] == 2'b00) begin
      if (have_hi) exp_fe++;
      m_hi = b[4:0]; have_hi = 1; ticks_waiting = 0;
    end else if (have_hi && b[7:5] == 3'b000) begin
      y = m_hi * 32 + b[4:0];
      exp_y = (y > 668) ? 10'd668 : 10'(y);
      exp_pv++; exp_link = 30; have_hi = 0;
    end else begin exp_fe++; have_hi = 0; end
  endtask

  task automatic model_reset();
    exp_y = 10'd334; exp_link = 0; have_hi = 0; ticks_waiting = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk) rx = 1'b0;
    repeat (DIV - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = b[i];
      repeat (DIV - 1) @(negedge clk);
    end
    @(negedge clk) rx = stop_ok;
    repeat (DIV - 1) @(negedge clk);
    @(negedge clk) rx = 1'b1;
    repeat (DIV) @(negedge clk);
    model_byte(b, stop_ok);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) timing_tick = 1'b1;
      @(negedge clk) timing_tick = 1'b0;
      if (exp_link > 0) exp_link--;
      if (have_hi) begin ticks_waiting++; if (ticks_waiting == 2) have_hi = 0; end
    end
  endtask

  task automatic send_frame(input logic [9:0] y);
    send_byte({3'b100, y[9:5]}, 1'b1);
    send_byte({3'b000, y[4:0]}, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0; repeat (4) @(negedge clk);
    rst = 1'b1; repeat (4) @(negedge clk);
    tests++; if (y_pad_uart !== 10'd334) begin fails++; $display("FAIL reset_y: got %0d want 334", y_pad_uart); end
    tests++; if (link_up !== 1'b0) begin fails++; $display("FAIL reset_link: got %b want 0", link_up); end
    tests++; if (pad_valid !== 1'b0 || frame_err !== 1'b0) begin fails++; $display("FAIL reset_pulses: pv %b fe %b want 0 0", pad_valid, frame_err); end
  endtask

  task automatic test_basic_frame();
    send_byte(8'h8A, 1'b1); send_byte(8'h0C, 1'b1);
    tests++; if (y_pad_uart !== 10'd332) begin fails++; $display("FAIL basic_y: got %0d want 332", y_pad_uart); end
    tests++; if (pv_cnt !== exp_pv) begin fails++; $display("FAIL basic_pv: got %0d want %0d", pv_cnt, exp_pv); end
    tests++; if (pv_wide !== 0) begin fails++; $display("FAIL basic_pv_width: %0d wide pulses want 0", pv_wide); end
    tests++; if (link_up !== 1'b1) begin fails++; $display("FAIL basic_link: got %b want 1", link_up); end
  endtask

  task automatic test_clamp();
    send_byte(8'h9F, 1'b1); send_byte(8'h1F, 1'b1);
    tests++; if (y_pad_uart !== 10'd668) begin fails++; $display("FAIL clamp_y: got %0d want 668", y_pad_uart); end
    tests++; if (fe_cnt !== exp_fe) begin fails++; $display("FAIL clamp_fe: got %0d want %0d", fe_cnt, exp_fe); end
    tests++; if (pv_cnt !== exp_pv) begin fails++; $display("FAIL clamp_pv: got %0d want %0d", pv_cnt, exp_pv); end
  endtask

  task automatic test_stop_err();
    send_byte(8'h8A, 1'b0);
    tests++; if (fe_cnt !== exp_fe) begin fails++; $display("FAIL stop_fe: got %0d want %0d", fe_cnt, exp_fe); end
    tests++; if (y_pad_uart !== 10'd668) begin fails++; $display("FAIL stop_y: got %0d want 668", y_pad_uart); end
    send_frame(10'd500);
    tests++; if (y_pad_uart !== 10'd500) begin fails++; $display("FAIL stop_next_y: got %0d want 500", y_pad_uart); end
  endtask

  task automatic test_resync();
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'h8A, 1'b1); send_byte(8'h85, 1'b1); send_byte(8'h0C, 1'b1);
    tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL resync_fe: got %0d want 1", fe_cnt - fe0); end
    tests++; if (y_pad_uart !== 10'd172) begin fails++; $display("FAIL resync_y: got %0d want 172", y_pad_uart); end
    tests++; if (both !== 0) begin fails++; $display("FAIL resync_overlap: got %0d want 0", both); end
  endtask

  task automatic test_glitch();
    int fe0, pv0;
    fe0 = fe_cnt; pv0 = pv_cnt;
    @(negedge clk) rx = 1'b0;
    repeat (DIV / 4 - 1) @(negedge clk);
    @(negedge clk) rx = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    tests++; if (fe_cnt !== fe0 || pv_cnt !== pv0) begin fails++; $display("FAIL glitch: fe %0d pv %0d want %0d %0d", fe_cnt, pv_cnt, fe0, pv0); end
  endtask

  task automatic test_wait_timeout();
    send_byte(8'h83, 1'b1); tick_n(1); send_byte(8'h04, 1'b1);
    tests++; if (y_pad_uart !== 10'd100) begin fails++; $display("FAIL one_tick_y: got %0d want 100", y_pad_uart); end
    send_byte(8'h84, 1'b1); tick_n(2); send_byte(8'h04, 1'b1);
    tests++; if (fe_cnt !== exp_fe) begin fails++; $display("FAIL two_tick_fe: got %0d want %0d", fe_cnt, exp_fe); end
    tests++; if (y_pad_uart !== exp_y) begin fails++; $display("FAIL two_tick_y: got %0d want %0d", y_pad_uart, exp_y); end
  endtask

  task automatic test_link_timeout();
    send_frame(10'd200);
    tick_n(29);
    tests++; if (link_up !== 1'b1) begin fails++; $display("FAIL link_29: got %b want 1", link_up); end
    tick_n(1);
    tests++; if (link_up !== 1'b0) begin fails++; $display("FAIL link_30: got %b want 0", link_up); end
    tests++; if (y_pad_uart !== 10'd200) begin fails++; $display("FAIL link_hold_y: got %0d want 200", y_pad_uart); end
  endtask

  task automatic test_mid_reset();
    int fe0, pv0;
    send_frame(10'd50);
    send_byte(8'h9E, 1'b1);
    @(negedge clk) rx = 1'b0;
    repeat (DIV - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) rx = 1'(i % 2);
      repeat (DIV - 1) @(negedge clk);
    end
    @(negedge clk) begin rst = 1'b0; rx = 1'b0; end
    repeat (3) @(negedge clk);
    model_reset();
    tests++; if (y_pad_uart !== 10'd334 || link_up !== 1'b0) begin fails++; $display("FAIL midrst_out: y %0d link %b want 334 0", y_pad_uart, link_up); end
    fe0 = fe_cnt; pv0 = pv_cnt;
    rst = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    tests++; if (fe_cnt !== fe0 || pv_cnt !== pv0) begin fails++; $display("FAIL midrst_low_line: fe %0d pv %0d want %0d %0d", fe_cnt, pv_cnt, fe0, pv0); end
    send_byte(8'h0A, 1'b1);
    tests++; if (y_pad_uart !== 10'd334) begin fails++; $display("FAIL midrst_partial: got %0d want 334", y_pad_uart); end
    send_frame(10'd77);
    tests++; if (y_pad_uart !== 10'd77) begin fails++; $display("FAIL midrst_after: got %0d want 77", y_pad_uart); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) send_frame(10'($urandom_range(0, 1023)));
      else if (r == 6) send_byte(8'($urandom), 1'b1);
      else if (r == 7) send_byte(8'($urandom), 1'b0);
      else if (r == 8) send_byte({3'b100, 5'($urandom)}, 1'b1);
      else begin
        @(negedge clk) rx = 1'b0;
        repeat (DIV / 4 - 1) @(negedge clk);
        @(negedge clk) rx = 1'b1;
        repeat (12 * DIV) @(negedge clk);
      end
      tests++; if (y_pad_uart !== exp_y) begin fails++; $display("FAIL rand_y[%0d]: got %0d want %0d", i, y_pad_uart, exp_y); end
      tests++; if (pv_cnt !== exp_pv || fe_cnt !== exp_fe) begin fails++; $display("FAIL rand_pulses[%0d]: pv %0d fe %0d want %0d %0d", i, pv_cnt, fe_cnt, exp_pv, exp_fe); end
      tests++; if (link_up !== (exp_link != 0)) begin fails++; $display("FAIL rand_link[%0d]: got %b want %b", i, link_up, exp_link != 0); end
    end
    tests++; if (pv_wide !== 0 || both !== 0) begin fails++; $display("FAIL rand_pulse_shape: wide %0d overlap %0d want 0 0", pv_wide, both); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_clamp();
    test_stop_err();
    test_resync();
    test_glitch();
    test_wait_timeout();
    test_link_timeout();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
